// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if
// Read-side handshake between the receive FIFO and the bus logic.
//   rd_valid : FIFO holds at least one byte (driven by the receiver)
//   rd_data  : FIFO head, zero when empty (driven by the receiver)
//   rd_ready : pop request (driven by the bus side)
// The master modport is the receiver (data producer); slave is the consumer.
interface uart_rx_frontend_if #(
  parameter int DATA_BITS = 8
);
  logic                 rd_valid;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_ready;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
// UART receive front end: synchronises ser_rx, recovers 8N1-style frames with
// a programmable clocks-per-bit divisor, and buffers bytes in a small
// first-word-fall-through FIFO. Framing and overrun errors are sticky.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   ser_rx       : asynchronous serial input, idles high
//   rx_enable    : receiver enable; low aborts a frame in progress
//   clk_div      : bit period minus one, in clk cycles (>= 3)
//   rd           : FIFO read handshake (rd_valid / rd_data / rd_ready)
//   fifo_level   : number of stored bytes
//   rx_busy      : receiver FSM not idle
//   frame_err    : sticky, stop bit sampled low
//   overrun      : sticky, byte dropped because the FIFO was full
//   err_clr      : single-cycle clear of both sticky flags
module uart_rx_frontend #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ser_rx,
  input  logic                          rx_enable,
  input  logic [31:0]                   clk_div,
  uart_rx_frontend_if.master            rd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_reg;
  logic [31:0]          cnt_reg;
  logic [BW-1:0]        bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 sync1_reg, sync2_reg, prev_reg;
  logic                 frame_err_reg, overrun_reg;
  logic [AW:0]          wr_ptr_reg, rd_ptr_reg;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic [31:0] half;
  logic        start_edge;
  logic        stop_hit, push, bad_stop;
  logic        empty, full, pop, push_ok, overrun_set;
  logic [AW:0] level;

  assign half       = clk_div >> 1;
  assign start_edge = prev_reg && !sync2_reg;

  // Stop-bit sample cycle; gated by rx_enable since disable wins over the FSM.
  assign stop_hit = (state_reg == STOP) && (cnt_reg == clk_div) && rx_enable;
  assign push     = stop_hit && sync2_reg;
  assign bad_stop = stop_hit && !sync2_reg;

  assign level       = wr_ptr_reg - rd_ptr_reg;
  assign empty       = (level == '0);
  assign full        = (level == DEPTH_LVL);
  assign pop         = !empty && rd.rd_ready;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok     = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  // Input synchroniser plus edge-history flop, all idle-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= ser_rx;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // Frame recovery FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else if (!rx_enable) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          // Needs a fresh falling edge, so a held-low line never retriggers.
          if (start_edge) begin
            state_reg   <= START;
            bit_cnt_reg <= '0;
          end
        end
        START: begin
          if (cnt_reg == half) begin
            cnt_reg   <= '0;
            state_reg <= sync2_reg ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        DATA: begin
          if (cnt_reg == clk_div) begin
            cnt_reg     <= '0;
            shift_reg   <= {sync2_reg, shift_reg[DATA_BITS-1:1]};
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
            if (bit_cnt_reg == LAST_BIT) state_reg <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        STOP: begin
          if (cnt_reg == clk_div) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // FIFO pointers carry one extra wrap bit so full and empty differ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
    end
  end

  // Storage has no reset; empty gating keeps rd_data at zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
  end

  // Sticky flags: a set event beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (bad_stop)     frame_err_reg <= 1'b1;
      else if (err_clr) frame_err_reg <= 1'b0;
      if (overrun_set)  overrun_reg   <= 1'b1;
      else if (err_clr) overrun_reg   <= 1'b0;
    end
  end

  assign rd.rd_valid = !empty;
  assign rd.rd_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign fifo_level  = level;
  assign rx_busy     = (state_reg != IDLE);
  assign frame_err   = frame_err_reg;
  assign overrun     = overrun_reg;
endmodule
